// File: rtl/serdesphy_rx_deserializer.sv
// Receive deserializer: hunts bit-by-bit for SYNC_WORD, then emits FRAME_BYTES
// payload bytes per frame and flywheels over isolated sync misses.
module serdesphy_rx_deserializer #(
    parameter logic [7:0] SYNC_WORD   = 8'hD5,
    parameter int         FRAME_BYTES = 4,
    parameter int         LOSS_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_serial_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_locked_o,
    output logic       sync_err_o,
    output logic [7:0] err_count_o
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [3:0] LAST_BYTE  = 4'(FRAME_BYTES - 1);
    localparam logic [2:0] LOSS_LIMIT = 3'(LOSS_THRESH);

    state_t      state_r;
    logic [7:0]  sr_r;
    logic [2:0]  bit_cnt_r;
    logic [3:0]  byte_cnt_r;
    logic [2:0]  miss_cnt_r;
    logic [7:0]  nsr_s;
    logic [2:0]  miss_next_s;
    logic        sync_hit_s;

    // Window including the bit sampled this cycle, and the prospective miss count
    always_comb begin
        nsr_s       = {sr_r[6:0], rx_serial_i};
        miss_next_s = miss_cnt_r + 3'd1;
        sync_hit_s  = (nsr_s == SYNC_WORD);
    end

    // Framing FSM with registered byte, strobe, lock and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            sr_r        <= 8'd0;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= 4'd0;
            miss_cnt_r  <= 3'd0;
            rx_data_o   <= 8'd0;
            rx_valid_o  <= 1'b0;
            rx_locked_o <= 1'b0;
            sync_err_o  <= 1'b0;
            err_count_o <= 8'd0;
        end else if (!ena) begin
            rx_valid_o <= 1'b0;
            sync_err_o <= 1'b0;
        end else begin
            sr_r       <= nsr_s;
            rx_valid_o <= 1'b0;
            sync_err_o <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (sync_hit_s) begin
                        state_r     <= DATA;
                        rx_locked_o <= 1'b1;
                        bit_cnt_r   <= 3'd0;
                        byte_cnt_r  <= 4'd0;
                        miss_cnt_r  <= 3'd0;
                    end
                end
                DATA: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        rx_data_o  <= nsr_s;
                        rx_valid_o <= 1'b1;
                        if (byte_cnt_r == LAST_BYTE) begin
                            state_r    <= CHECK;
                            byte_cnt_r <= 4'd0;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 4'd1;
                        end
                    end
                end
                CHECK: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        if (sync_hit_s) begin
                            miss_cnt_r <= 3'd0;
                            state_r    <= DATA;
                        end else begin
                            sync_err_o <= 1'b1;
                            if (err_count_o != 8'hFF) begin
                                err_count_o <= err_count_o + 8'd1;
                            end
                            // Only a run of LOSS_THRESH misses abandons the current alignment
                            if (miss_next_s == LOSS_LIMIT) begin
                                state_r     <= HUNT;
                                rx_locked_o <= 1'b0;
                                miss_cnt_r  <= 3'd0;
                            end else begin
                                state_r    <= DATA;
                                miss_cnt_r <= miss_next_s;
                            end
                        end
                    end
                end
                default: begin
                    state_r     <= HUNT;
                    rx_locked_o <= 1'b0;
                    bit_cnt_r   <= 3'd0;
                    byte_cnt_r  <= 4'd0;
                    miss_cnt_r  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdesphy_rx_deserializer.sv
// Randomized bench for serdesphy_rx_deserializer, checked cycle by cycle against
// a frame-position reference model (one DUT with LOSS_THRESH=2, one with 1).
module tb_serdesphy_rx_deserializer;

    localparam int         FB   = 4;
    localparam logic [7:0] SYNC = 8'hD5;

    logic       clk = 1'b0;
    logic       rst_n, ena, rx_serial;
    logic [7:0] d0_data, d0_cnt, d1_data, d1_cnt;
    logic       d0_valid, d0_locked, d0_err, d1_valid, d1_locked, d1_err;

    serdesphy_rx_deserializer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_serial_i(rx_serial),
        .rx_data_o(d0_data), .rx_valid_o(d0_valid), .rx_locked_o(d0_locked),
        .sync_err_o(d0_err), .err_count_o(d0_cnt)
    );

    serdesphy_rx_deserializer #(.LOSS_THRESH(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_serial_i(rx_serial),
        .rx_data_o(d1_data), .rx_valid_o(d1_valid), .rx_locked_o(d1_locked),
        .sync_err_o(d1_err), .err_count_o(d1_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       locked;
        logic       err;
        logic [7:0] cnt;
    } snap_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         use_l1  = 1'b0;
    int         m_loss;
    logic       hist[$];
    logic       m_locked, m_valid, m_err;
    int         m_base, m_miss;
    logic [7:0] m_data, m_cnt;
    snap_t      obs_q[$];
    snap_t      exp_q[$];

    // Reference model: frame positions are counted from the end of the last sync byte.
    task automatic model_reset();
        hist.delete();
        m_locked = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        m_base = 0; m_miss = 0; m_data = 8'd0; m_cnt = 8'd0;
        m_loss = use_l1 ? 1 : 2;
    endtask

    function automatic logic [7:0] window();
        logic [7:0] w;
        int idx;
        w = 8'd0;
        for (int i = 0; i < 8; i++) begin
            idx = hist.size() - 8 + i;
            w[7-i] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return w;
    endfunction

    task automatic model_step(input logic b, input logic e);
        logic [7:0] w;
        int k, d;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (e) begin
            hist.push_back(b);
            k = hist.size() - 1;
            w = window();
            if (!m_locked) begin
                if (w == SYNC) begin
                    m_locked = 1'b1; m_base = k; m_miss = 0;
                end
            end else begin
                d = k - m_base;
                if (d % 8 == 0) begin
                    if (d / 8 <= FB) begin
                        m_valid = 1'b1; m_data = w;
                    end else begin
                        m_base = k;
                        if (w == SYNC) m_miss = 0;
                        else begin
                            m_err = 1'b1;
                            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                            m_miss++;
                            if (m_miss == m_loss) begin
                                m_locked = 1'b0; m_miss = 0;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic b, input logic e);
        snap_t o, x;
        rx_serial = b;
        ena       = e;
        @(posedge clk);
        #1;
        model_step(b, e);
        o = use_l1 ? {d1_valid, d1_data, d1_locked, d1_err, d1_cnt}
                   : {d0_valid, d0_data, d0_locked, d0_err, d0_cnt};
        x = {m_valid, m_data, m_locked, m_err, m_cnt};
        obs_q.push_back(o);
        exp_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b0; rx_serial = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int shown;
        use_l1 = 1'b0;
        rst_n = 1'b0; ena = 1'b1; rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({d0_valid, d0_data, d0_locked, d0_err, d0_cnt, d1_valid, d1_data, d1_locked, d1_err, d1_cnt} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_values got=%h/%h required all zero", {d0_valid, d0_data, d0_locked, d0_err, d0_cnt},
                     {d1_valid, d1_data, d1_locked, d1_err, d1_cnt});
        end
        do_reset();
        repeat (40) step(1'b0, 1'b1);
        shown = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== 19'd0 || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                if (shown < 8) $display("FAIL idle_trace cyc=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                shown++;
            end
        end
    endtask

    task automatic test_acquire();
        logic [7:0] stream[11];
        logic [7:0] want[8];
        logic [7:0] got[$];
        int shown;
        stream = '{8'hD5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hD5, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hD5};
        want   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        use_l1 = 1'b0;
        do_reset();
        repeat (3) step(1'($urandom), 1'b1);
        foreach (stream[i]) send_byte(stream[i]);
        shown = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                if (shown < 8) $display("FAIL acquire_trace cyc=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                shown++;
            end
            if (obs_q[i].valid) got.push_back(obs_q[i].data);
        end
        n_tests++;
        if (obs_q[9].locked !== 1'b0 || obs_q[10].locked !== 1'b1) begin
            n_fail++;
            $display("FAIL acquire_lock_edge got=%b%b required=01", obs_q[9].locked, obs_q[10].locked);
        end
        n_tests++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL acquire_byte_count got=%0d required=8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (got[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL acquire_byte%0d got=%h required=%h", i, got[i], want[i]);
                end
            end
        end
        n_tests++;
        if (d0_cnt !== 8'd0 || d0_err !== 1'b0) begin
            n_fail++;
            $display("FAIL acquire_no_err got=%0d required=0", d0_cnt);
        end
    endtask

    task automatic test_flywheel();
        logic [7:0] p[12];
        logic [7:0] got[$];
        int errs, shown;
        use_l1 = 1'b0;
        foreach (p[i]) p[i] = 8'($urandom);
        do_reset();
        send_byte(SYNC);
        for (int i = 0; i < 4; i++) send_byte(p[i]);
        send_byte(8'hD4);
        for (int i = 4; i < 8; i++) send_byte(p[i]);
        send_byte(SYNC);
        for (int i = 8; i < 12; i++) send_byte(p[i]);
        send_byte(SYNC);
        errs = 0; shown = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i] || (i >= 7 && obs_q[i].locked !== 1'b1)) begin
                n_fail++;
                if (shown < 8) $display("FAIL flywheel_trace cyc=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                shown++;
            end
            if (obs_q[i].valid) got.push_back(obs_q[i].data);
            if (obs_q[i].err) errs++;
        end
        n_tests++;
        if (errs != 1 || d0_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL flywheel_err got=%0d/%0d required=1/1", errs, d0_cnt);
        end
        n_tests++;
        if (got.size() != 12) begin
            n_fail++;
            $display("FAIL flywheel_byte_count got=%0d required=12", got.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_tests++;
                if (got[i] !== p[i]) begin
                    n_fail++;
                    $display("FAIL flywheel_byte%0d got=%h required=%h", i, got[i], p[i]);
                end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        logic [7:0] p[12];
        logic [7:0] got[$];
        int shown;
        use_l1 = 1'b0;
        foreach (p[i]) p[i] = 8'($urandom);
        do_reset();
        send_byte(SYNC);
        for (int i = 0; i < 4; i++) send_byte(p[i]);
        send_byte(8'hD4);
        for (int i = 4; i < 8; i++) send_byte(p[i]);
        send_byte(8'hD4);
        repeat (3) step(1'b0, 1'b1);
        send_byte(SYNC);
        for (int i = 8; i < 12; i++) send_byte(p[i]);
        send_byte(SYNC);
        shown = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                if (shown < 8) $display("FAIL loss_trace cyc=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                shown++;
            end
            if (obs_q[i].valid) got.push_back(obs_q[i].data);
        end
        n_tests++;
        if (obs_q[86].locked !== 1'b1 || obs_q[87].locked !== 1'b0 || obs_q[87].cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL loss_drop got=%b%b cnt=%0d required=10 cnt=2", obs_q[86].locked, obs_q[87].locked, obs_q[87].cnt);
        end
        n_tests++;
        if (obs_q[97].locked !== 1'b0 || obs_q[98].locked !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_relock got=%b%b required=01", obs_q[97].locked, obs_q[98].locked);
        end
        n_tests++;
        if (got.size() != 12 || got[8] !== p[8] || got[11] !== p[11]) begin
            n_fail++;
            $display("FAIL loss_realigned_bytes got=%0d bytes required=12 with new-alignment payload", got.size());
        end
    endtask

    task automatic test_ena_gating();
        logic [7:0] p[4];
        int shown;
        use_l1 = 1'b0;
        foreach (p[i]) p[i] = 8'($urandom);
        do_reset();
        send_byte(SYNC);
        for (int i = 7; i >= 5; i--) step(p[0][i], 1'b1);
        repeat (5) step(1'($urandom), 1'b0);
        for (int i = 4; i >= 0; i--) step(p[0][i], 1'b1);
        for (int i = 1; i < 4; i++) send_byte(p[i]);
        send_byte(SYNC);
        shown = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                if (shown < 8) $display("FAIL ena_trace cyc=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                shown++;
            end
        end
        n_tests++;
        if ({obs_q[15].valid, obs_q[16].valid, obs_q[17].valid, obs_q[18].valid, obs_q[19].valid} !== 5'd0) begin
            n_fail++;
            $display("FAIL ena_early_strobe got=%b required=00000",
                     {obs_q[15].valid, obs_q[16].valid, obs_q[17].valid, obs_q[18].valid, obs_q[19].valid});
        end
        n_tests++;
        if (obs_q[20].valid !== 1'b1 || obs_q[20].data !== p[0]) begin
            n_fail++;
            $display("FAIL ena_delayed_byte got=%b/%h required=1/%h", obs_q[20].valid, obs_q[20].data, p[0]);
        end
    endtask

    task automatic test_saturation_async_reset();
        int errs, shown, late;
        use_l1 = 1'b1;
        do_reset();
        for (int f = 0; f < 300; f++) begin
            send_byte(SYNC);
            repeat (FB) send_byte(8'($urandom));
            send_byte(8'h00);
        end
        errs = 0; shown = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                if (shown < 8) $display("FAIL sat_trace cyc=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
                shown++;
            end
            if (obs_q[i].err) errs++;
        end
        n_tests++;
        if (errs != 300 || d1_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_count got=%0d strobes cnt=%0d required=300 cnt=255", errs, d1_cnt);
        end
        send_byte(SYNC);
        send_byte(8'($urandom));
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({d1_valid, d1_data, d1_locked, d1_err, d1_cnt, d0_valid, d0_locked, d0_cnt} !== 29'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%h/%b%b%h required all zero",
                     {d1_valid, d1_data, d1_locked, d1_err, d1_cnt}, d0_valid, d0_locked, d0_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        obs_q.delete();
        exp_q.delete();
        repeat (16) step(1'b0, 1'b1);
        late = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].valid || obs_q[i].locked || obs_q[i].cnt != 8'd0) late++;
        end
        n_tests++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet got=%0d active cycles required=0", late);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; rx_serial = 1'b0;
        model_reset();
        test_reset();
        test_acquire();
        test_flywheel();
        test_loss_of_lock();
        test_ena_gating();
        test_saturation_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdesphy_rx_deserializer.md
Name: serdesphy_rx_deserializer

Overview:
- Receive-side stage of the SerDes PHY. It consumes the 1-bit serial line one bit per clock and finds frame alignment by hunting for a sync byte.
- Once aligned, it emits the payload bytes of each frame on a parallel byte bus with a valid strobe, tracks lock, and flags sync errors.
- It sits directly behind the pad input in the TinyTapeout top; its byte output feeds the top-level output pins.

Parameters:
- SYNC_WORD, 8'hD5: frame delimiter, compared MSB-first.
- FRAME_BYTES, 4: payload bytes between consecutive sync words; legal range 1..15.
- LOSS_THRESH, 2: consecutive missed sync words that drop lock; legal range 1..7.

Ports:
- clk  input  1  system clock; one serial bit per cycle while ena=1.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  bit-enable; when 0, all state is frozen.
- rx_serial_i  input  1  serial data in, MSB of each byte first.
- rx_data_o  output  8  last completed payload byte.
- rx_valid_o  output  1  one-cycle strobe; rx_data_o is new this cycle.
- rx_locked_o  output  1  frame alignment held.
- sync_err_o  output  1  one-cycle strobe on each missed sync word while locked.
- err_count_o  output  8  saturating count of sync errors since reset.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). Reset values:
  - rx_data_o=0, rx_valid_o=0, rx_locked_o=0, sync_err_o=0, err_count_o=0.
  - Shift register=0, state=HUNT, bit_cnt=0, byte_cnt=0, miss_cnt=0.
- Shift register: on each ena=1 cycle, nsr = {sr[6:0], rx_serial_i} and sr <= nsr. All comparisons and captures use nsr, i.e. they include the bit sampled this cycle.
- ena=0: no state changes. Strobes rx_valid_o and sync_err_o are forced to 0 that cycle. Level outputs hold.
- FSM states: HUNT, DATA, CHECK.
- HUNT:
  - If nsr==SYNC_WORD: go to DATA, set rx_locked_o=1, clear bit_cnt, byte_cnt and miss_cnt.
  - Otherwise stay in HUNT. Alignment is bit-granular: every cycle is tested.
- DATA:
  - bit_cnt increments each ena cycle.
  - When bit_cnt==7: rx_data_o<=nsr, rx_valid_o=1 on the next cycle, bit_cnt wraps to 0.
  - After the strobe for payload byte FRAME_BYTES-1, go to CHECK with byte_cnt=0; otherwise byte_cnt++.
- CHECK: collect 8 bits. At bit_cnt==7, compare nsr with SYNC_WORD:
  - Match: miss_cnt=0, go to DATA.
  - Mismatch (flywheel): sync_err_o pulses, err_count_o increments and saturates at 255, miss_cnt++.
    - If the new miss_cnt==LOSS_THRESH: go to HUNT, rx_locked_o=0, miss_cnt=0.
    - Otherwise go to DATA, keeping the existing alignment.
  - The sync byte is never presented on rx_data_o.
- Latency: the final bit of a payload byte is sampled at edge N; rx_valid_o and the new rx_data_o are visible after edge N, for exactly one cycle. rx_data_o holds until the next byte.
- rx_locked_o rises on the edge that detects sync in HUNT and falls on the edge of the LOSS_THRESH-th consecutive miss.
- A HUNT match needs no prior history: a sync that straddles the reset release is found once 8 bits have been shifted in after reset.
- Asserting rst_n mid-frame aborts immediately. A strobe in flight is cleared and no partial byte is emitted.
- No bypass path; the PHY top registers nothing further.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then stream all-zero bits for 40 cycles. Required: all outputs stay 0 and the FSM stays in HUNT.
- Acquire and decode: send 3 random bits, then D5, 11, 22, 33, 44, D5, A0, A1, A2, A3, D5 MSB-first with ena=1 throughout.
  - rx_locked_o rises the cycle after the last bit of the first D5.
  - rx_valid_o pulses 8 times with data 11,22,33,44,A0,A1,A2,A3, each 1 cycle after that byte's last bit.
  - sync_err_o stays 0 and err_count_o=0.
- Flywheel: after lock, corrupt one sync to D4 and send the next sync correct. Required:
  - sync_err_o pulses once and err_count_o=1.
  - rx_locked_o stays 1.
  - The payload after the bad sync is still decoded at the original alignment.
- Loss of lock: after lock, corrupt two consecutive syncs (LOSS_THRESH=2). Required:
  - err_count_o=2.
  - rx_locked_o falls at the second bad sync.
  - A later D5 preceded by a 3-bit slip re-locks at the new alignment.
- ena gating: during a locked frame, drop ena for 5 cycles mid-byte while changing rx_serial_i. Required: the byte is unaffected, rx_valid_o is delayed by exactly 5 cycles and has the same value.
- Saturation and async reset: force 300 sync misses with LOSS_THRESH=1 and repeated re-hunts. Required:
  - err_count_o sticks at 255.
  - A mid-byte rst_n pulse clears everything with no trailing rx_valid_o.
